// File: rtl/lagarto_dcache_req_responder_if.sv
// Split load/store request bus between the core's dcache port and the responder,
// plus the single-outstanding backing memory port.
interface lagarto_dcache_req_responder_if #(
   parameter int DCACHE_INDEX_WIDTH = 12,
   parameter int DCACHE_TAG_WIDTH   = 44
);
   localparam int ADDR_W = DCACHE_TAG_WIDTH + DCACHE_INDEX_WIDTH;

   logic                          ld_req_valid;
   logic [DCACHE_INDEX_WIDTH-1:0] ld_req_index;
   logic [1:0]                    ld_req_size;
   logic                          ld_req_tag_valid;
   logic [DCACHE_TAG_WIDTH-1:0]   ld_req_tag;
   logic                          ld_req_kill;
   logic                          st_req_valid;
   logic [DCACHE_INDEX_WIDTH-1:0] st_req_index;
   logic [DCACHE_TAG_WIDTH-1:0]   st_req_tag;
   logic [63:0]                   st_req_wdata;
   logic [7:0]                    st_req_be;
   logic [1:0]                    st_req_size;

   logic                          mem_req;
   logic                          mem_we;
   logic [ADDR_W-1:0]             mem_addr;
   logic [63:0]                   mem_wdata;
   logic [7:0]                    mem_be;
   logic                          mem_gnt;
   logic                          mem_rvalid;
   logic [63:0]                   mem_rdata;

   logic                          dmem_resp_valid;
   logic [63:0]                   dmem_resp_data;
   logic                          dmem_resp_nack;
   logic                          dmem_xcpt_ma_ld;
   logic                          dmem_xcpt_ma_st;

   // Responder side: takes core requests and memory completions.
   modport slave (
      input  ld_req_valid, ld_req_index, ld_req_size, ld_req_tag_valid, ld_req_tag, ld_req_kill,
      input  st_req_valid, st_req_index, st_req_tag, st_req_wdata, st_req_be, st_req_size,
      output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
      input  mem_gnt, mem_rvalid, mem_rdata,
      output dmem_resp_valid, dmem_resp_data, dmem_resp_nack, dmem_xcpt_ma_ld, dmem_xcpt_ma_st
   );

   // Environment side: the core plus the backing memory.
   modport master (
      output ld_req_valid, ld_req_index, ld_req_size, ld_req_tag_valid, ld_req_tag, ld_req_kill,
      output st_req_valid, st_req_index, st_req_tag, st_req_wdata, st_req_be, st_req_size,
      input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
      output mem_gnt, mem_rvalid, mem_rdata,
      input  dmem_resp_valid, dmem_resp_data, dmem_resp_nack, dmem_xcpt_ma_ld, dmem_xcpt_ma_st
   );
endinterface

// File: rtl/lagarto_dcache_req_responder.sv
// Dcache-side responder: accepts one load (index then tag phase) or store at a time,
// checks alignment, runs one access on the backing memory and returns a response pulse.
module lagarto_dcache_req_responder #(
   parameter int DCACHE_INDEX_WIDTH = 12,
   parameter int DCACHE_TAG_WIDTH   = 44
) (
   input logic                            clk,
   input logic                            rst,
   lagarto_dcache_req_responder_if.slave  bus
);
   localparam int ADDR_W = DCACHE_TAG_WIDTH + DCACHE_INDEX_WIDTH;

   localparam logic [2:0] IDLE    = 3'd0;
   localparam logic [2:0] LD_TAG  = 3'd1;
   localparam logic [2:0] LD_REQ  = 3'd2;
   localparam logic [2:0] LD_WAIT = 3'd3;
   localparam logic [2:0] ST_REQ  = 3'd4;
   localparam logic [2:0] ST_WAIT = 3'd5;
   localparam logic [2:0] DROP    = 3'd6;

   logic [2:0]                    state;
   logic [DCACHE_INDEX_WIDTH-1:0] idx_q;
   logic [DCACHE_TAG_WIDTH-1:0]   tag_q;
   logic [1:0]                    size_q;
   logic [63:0]                   wdata_q;
   logic [7:0]                    be_q;

   logic                          resp_valid_q;
   logic [63:0]                   resp_data_q;
   logic                          nack_q;
   logic                          ma_ld_q;
   logic                          ma_st_q;

   function automatic logic misaligned(input logic [2:0] off, input logic [1:0] size);
      case (size)
         2'd0:    return 1'b0;
         2'd1:    return off[0];
         2'd2:    return |off[1:0];
         default: return |off;
      endcase
   endfunction

   // Any request that is not taken this cycle is refused, never queued.
   logic refuse;
   assign refuse = (state != IDLE) ? (bus.ld_req_valid | bus.st_req_valid)
                                   : (bus.ld_req_valid & bus.st_req_valid);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         idx_q        <= '0;
         tag_q        <= '0;
         size_q       <= '0;
         wdata_q      <= '0;
         be_q         <= '0;
         resp_valid_q <= 1'b0;
         resp_data_q  <= '0;
         nack_q       <= 1'b0;
         ma_ld_q      <= 1'b0;
         ma_st_q      <= 1'b0;
      end else begin
         resp_valid_q <= 1'b0;
         ma_ld_q      <= 1'b0;
         ma_st_q      <= 1'b0;
         nack_q       <= refuse;
         case (state)
            IDLE: begin
               if (bus.ld_req_valid) begin
                  idx_q  <= bus.ld_req_index;
                  size_q <= bus.ld_req_size;
                  state  <= LD_TAG;
               end else if (bus.st_req_valid) begin
                  if (misaligned(bus.st_req_index[2:0], bus.st_req_size)) begin
                     ma_st_q      <= 1'b1;
                     resp_valid_q <= 1'b1;
                  end else begin
                     idx_q   <= bus.st_req_index;
                     tag_q   <= bus.st_req_tag;
                     size_q  <= bus.st_req_size;
                     wdata_q <= bus.st_req_wdata;
                     be_q    <= bus.st_req_be;
                     state   <= ST_REQ;
                  end
               end
            end
            LD_TAG: begin
               if (bus.ld_req_kill) begin
                  state <= IDLE;
               end else if (bus.ld_req_tag_valid) begin
                  tag_q <= bus.ld_req_tag;
                  if (misaligned(idx_q[2:0], size_q)) begin
                     ma_ld_q      <= 1'b1;
                     resp_valid_q <= 1'b1;
                     state        <= IDLE;
                  end else begin
                     state <= LD_REQ;
                  end
               end
            end
            LD_REQ: begin
               // A kill that lands on the grant cycle still owes memory a completion.
               if (bus.ld_req_kill)  state <= bus.mem_gnt ? DROP : IDLE;
               else if (bus.mem_gnt) state <= LD_WAIT;
            end
            LD_WAIT: begin
               if (bus.ld_req_kill) begin
                  state <= bus.mem_rvalid ? IDLE : DROP;
               end else if (bus.mem_rvalid) begin
                  resp_valid_q <= 1'b1;
                  resp_data_q  <= bus.mem_rdata >> {idx_q[2:0], 3'b000};
                  state        <= IDLE;
               end
            end
            ST_REQ: begin
               if (bus.mem_gnt) state <= ST_WAIT;
            end
            ST_WAIT: begin
               if (bus.mem_rvalid) begin
                  resp_valid_q <= 1'b1;
                  resp_data_q  <= '0;
                  state        <= IDLE;
               end
            end
            DROP: begin
               if (bus.mem_rvalid) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   logic [ADDR_W-1:0] addr_full;
   assign addr_full = {tag_q, idx_q};

   assign bus.mem_req   = (state == LD_REQ) || (state == ST_REQ);
   assign bus.mem_we    = (state == ST_REQ);
   assign bus.mem_addr  = {addr_full[ADDR_W-1:3], 3'b000};
   assign bus.mem_wdata = wdata_q;
   assign bus.mem_be    = (state == ST_REQ) ? be_q : ((state == LD_REQ) ? 8'hFF : 8'h00);

   assign bus.dmem_resp_valid = resp_valid_q;
   assign bus.dmem_resp_data  = resp_data_q;
   assign bus.dmem_resp_nack  = nack_q;
   assign bus.dmem_xcpt_ma_ld = ma_ld_q;
   assign bus.dmem_xcpt_ma_st = ma_st_q;
endmodule
